uart_tx_mmio: RTL
=================

// Module: uart_tx_mmio
// PURPOSE
//  Memory-mapped UART transmitter. Sits directly downstream of cpu6502 on its address/data bus.
//  Decodes CPU writes into a byte FIFO, serialises bytes as 8N1 frames on tx_out, and returns
//  status/divisor reads on data_out. The system read mux forwards data_out to cpu6502.data_in
//  whenever chip_select_out=1.
// PARAMETERS
//  BASE_ADDR        16'h8000  base of the 4-byte register window (low 2 bits must be 0)
//  FIFO_DEPTH       8         TX FIFO entries; power of 2, >=2
//  DEFAULT_DIVISOR  16'd434   clk_in cycles per bit after reset
// PORTS
//  clk_in           in   1   sole clock, rising edge
//  reset            in   1   synchronous, active-high
//  address_in       in   16  CPU address_out
//  data_in          in   8   CPU data_out
//  READ_write       in   1   CPU bus direction: 0=read, 1=write
//  data_out         out  8   read data, combinational from address_in and registered state
//  chip_select_out  out  1   address_in[15:2]==BASE_ADDR[15:2]; combinational
//  tx_out           out  1   serial line, idle high
//  tx_empty_irq     out  1   registered; 1 when FIFO empty and FSM in IDLE
// BEHAVIOUR
//  Register map (offset = address_in[1:0]):
//   0 TXDATA  W: push data_in. R: 8'h00
//   1 STATUS  R: {4'b0, overflow, busy, empty, full}. W: data_in[3]=1 clears overflow
//   2 DIVLO   R/W: divisor[7:0]
//   3 DIVHI   R/W: divisor[15:8]
//  Write strobe = chip_select_out & READ_write, sampled on every rising edge. Each cycle with
//   the strobe high is exactly one write; no wait states. Reads have no side effects.
//  data_out = 8'h00 when chip_select_out=0.
//  Reset values: tx_out=1, tx_empty_irq=1, FIFO empty, overflow=0, divisor=DEFAULT_DIVISOR,
//   FSM=IDLE, shift register=0. Reset mid-frame aborts the frame; tx_out=1 after that edge.
//  FIFO push/pop:
//   Push when full and no pop in the same cycle: byte dropped, overflow<=1 (sticky).
//   Push and pop in the same cycle while full: both happen; count unchanged; no overflow.
//   Overflow clear and a new overflow in the same cycle: set wins.
//  Bit period: eff_div = (divisor<2) ? 2 : divisor. A cycle counter runs 0..eff_div-1 and
//   gives a bit_end strobe. Divisor writes take effect at the next bit boundary; the counter
//   is not disturbed.
//  FSM states IDLE, START, DATA, STOP (typedef in package):
//   IDLE : if FIFO non-empty, pop into shift reg, counter<=0, tx_out<=0, go START.
//   START: at bit_end, tx_out<=shift[0], bit_idx<=0, go DATA.
//   DATA : at bit_end, shift>>=1, bit_idx++. After bit 7: tx_out<=1, go STOP.
//   STOP : at bit_end, if FIFO non-empty, pop and go START with tx_out<=0 (zero idle gap);
//          otherwise go IDLE.
//  Latency: write accepted at edge E0 into an empty, idle block -> pop at E1, tx_out low
//   from E1. Frame length = 10*eff_div cycles.
//  busy = (FSM != IDLE). full/empty/busy are registered-state views.
// STRUCTURE
//  Package peripheral_map: register offset enum (RegTxData, RegStatus, RegDivLo, RegDivHi),
//   STATUS bit index constants, uart_tx_state_t enum.
//  Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH): push, pop, full, empty, count.
//   Pointer MSB wrap distinguishes full from empty.
//  Top level contains the decode/read mux, divisor regs, baud counter, FSM and shifter.
// TESTING
//  1. Reset, divisor=4, write 8'hA5 to 16'h8000 -> tx_out bits 0,1,0,1,0,0,1,0,1,1,
//     each 4 cycles; tx_empty_irq=1 at frame end.
//  2. Write 8'h01 then 8'h02 back-to-back -> second start bit begins immediately after the
//     first stop bit (no idle cycle).
//  3. With FSM blocked (divisor=16'hFFFF) write 10 bytes -> first is popped, next 8 fill
//     the FIFO, 10th dropped; STATUS=8'h0D. Write 8'h08 to 16'h8001 -> STATUS=8'h05.
//  4. Write divisor 1 -> 2-cycle bits; read 16'h8002/16'h8003 -> 8'h01/8'h00.
//     Change divisor mid-frame -> new period only from the next bit.
//  5. Assert reset mid-DATA -> tx_out=1 the next cycle, STATUS=8'h02,
//     divisor reads DEFAULT_DIVISOR.
//  6. Read an unmapped address such as 16'h8004 -> chip_select_out=0, data_out=8'h00;
//     a CPU write there changes no state.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package peripheral_map;

  // Register offsets within the 4-byte window (address_in[1:0])
  typedef enum logic [1:0] {
    RegTxData = 2'd0,
    RegStatus = 2'd1,
    RegDivLo  = 2'd2,
    RegDivHi  = 2'd3
  } reg_off_t;

  // STATUS register bit positions
  localparam int StFull     = 0;
  localparam int StEmpty    = 1;
  localparam int StBusy     = 2;
  localparam int StOverflow = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  // Divisors below 2 would give a degenerate bit period; clamp to 2
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous byte FIFO; an extra pointer MSB tells full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // A pop frees the slot in the same cycle, so a push while full still lands
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: bus decode, TX FIFO, baud counter and 8N1 shifter.
module uart_tx_mmio
  import peripheral_map::*;
#(
  parameter logic [15:0] BASE_ADDR       = 16'h8000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [15:0] address_in,
  input  logic [7:0]  data_in,
  input  logic        READ_write,
  output logic [7:0]  data_out,
  output logic        chip_select_out,
  output logic        tx_out,
  output logic        tx_empty_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_off_t       off;
  logic           we, push, pop, clr_ovf, push_acc;
  logic           fifo_full, fifo_empty;
  logic [7:0]     fifo_rdata, status;
  logic [CW-1:0]  fifo_count, count_nxt;
  logic [15:0]    divisor_q;
  logic           ovf_q, ovf_d;
  uart_tx_state_t state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     idx_q, idx_d;
  logic [15:0]    cnt_q, cnt_d, period_q, period_d;
  logic           tx_q, tx_d, irq_q, irq_d, bit_end;

  assign chip_select_out = (address_in[15:2] == BASE_ADDR[15:2]);
  assign off      = reg_off_t'(address_in[1:0]);
  assign we       = chip_select_out & READ_write;
  assign push     = we & (off == RegTxData);
  assign clr_ovf  = we & (off == RegStatus) & data_in[3];
  assign push_acc = push & (~fifo_full | pop);
  assign count_nxt = fifo_count + {{(CW-1){1'b0}}, push_acc} - {{(CW-1){1'b0}}, pop};
  // A drop in the same cycle as a clear leaves overflow set
  assign ovf_d    = (push & fifo_full & ~pop) | (ovf_q & ~clr_ovf);
  assign bit_end  = (cnt_q == period_q - 16'd1);
  assign tx_out       = tx_q;
  assign tx_empty_irq = irq_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (data_in),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // STATUS byte assembled from registered state
  always_comb begin
    status             = 8'h00;
    status[StFull]     = fifo_full;
    status[StEmpty]    = fifo_empty;
    status[StBusy]     = (state_q != IDLE);
    status[StOverflow] = ovf_q;
  end

  // Read mux; zero outside the window and for TXDATA
  always_comb begin
    data_out = 8'h00;
    if (chip_select_out) begin
      case (off)
        RegStatus: data_out = status;
        RegDivLo:  data_out = divisor_q[7:0];
        RegDivHi:  data_out = divisor_q[15:8];
        default:   data_out = 8'h00;
      endcase
    end
  end

  // Divisor and sticky overflow registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      divisor_q <= DEFAULT_DIVISOR;
      ovf_q     <= 1'b0;
    end else begin
      if (we && off == RegDivLo) divisor_q[7:0]  <= data_in;
      if (we && off == RegDivHi) divisor_q[15:8] <= data_in;
      ovf_q <= ovf_d;
    end
  end

  // Frame sequencing; the bit period is latched only at bit boundaries
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
    period_d = period_q;
    cnt_d    = (state_q == IDLE || bit_end) ? 16'd0 : cnt_q + 16'd1;
    pop      = 1'b0;
    if (bit_end) period_d = eff_div(divisor_q);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_rdata;
          tx_d     = 1'b0;
          period_d = eff_div(divisor_q);
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    irq_d = (count_nxt == '0) && (state_d == IDLE);
  end

  // Transmit state registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= 8'h00;
      idx_q    <= 3'd0;
      tx_q     <= 1'b1;
      cnt_q    <= 16'd0;
      period_q <= eff_div(DEFAULT_DIVISOR);
      irq_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      irq_q    <= irq_d;
    end
  end

endmodule
